// File: rtl/fft_stage_pipe_if.sv
// Beat-level bus for one radix-2 FFT stage: input beat (samples, twiddles, mode) and output beat.
// Carries no state; the stage it connects to adds two cycles of latency.
// Backpressure: din_busy stalls the source, dout_busy stalls the stage.
interface fft_stage_pipe_if #(
  parameter int WIDTH  = 16,
  parameter int NPOINT = 3
);
  localparam int N = 1 << NPOINT;

  logic                     din_valid;
  logic                     din_busy;
  logic [WIDTH*N-1:0]       din_real;
  logic [WIDTH*N-1:0]       din_imag;
  logic [WIDTH*(N/2)-1:0]   din_weight_real;
  logic [WIDTH*(N/2)-1:0]   din_weight_imag;
  logic                     din_inverse;
  logic                     din_scale;
  logic                     dout_valid;
  logic                     dout_busy;
  logic [WIDTH*N-1:0]       dout_real;
  logic [WIDTH*N-1:0]       dout_imag;

  // Beat source and sink side (drives input beats, applies output backpressure).
  modport master (
    output din_valid, din_real, din_imag, din_weight_real, din_weight_imag,
           din_inverse, din_scale, dout_busy,
    input  din_busy, dout_valid, dout_real, dout_imag
  );

  // Butterfly stage side.
  modport slave (
    input  din_valid, din_real, din_imag, din_weight_real, din_weight_imag,
           din_inverse, din_scale, dout_busy,
    output din_busy, dout_valid, dout_real, dout_imag
  );
endinterface

// File: rtl/fft_stage_pipe.sv
// Fully parallel radix-2 butterfly stage: all N/2 butterflies of one stage per beat, one beat per clock.
// Latency 2 registers: twiddle multiply (S1), then add/sub into the output register (S2).
// Backpressure: dout_busy holds S2; S1 still fills if empty; din_busy = v1 & v2 & dout_busy.
module fft_stage_pipe #(
  parameter int WIDTH  = 16,
  parameter int NPOINT = 3,
  parameter int STEP   = 2,
  parameter int FRAC   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  fft_stage_pipe_if.slave  bus,
  input  logic             ovf_clr,
  output logic             ovf
);
  localparam int N  = 1 << NPOINT;
  localparam int NB = N / 2;
  localparam int GL = 1 << STEP;
  localparam int PW = 2 * WIDTH + 1;   // product/accumulate width
  localparam int SW = WIDTH + 2;       // add/sub width with headroom for the rounding increment
  localparam int LW = WIDTH * N;
  localparam int BW = WIDTH * NB;

  typedef logic signed [PW-1:0] wide_t;
  typedef logic signed [SW-1:0] sum_t;

  localparam wide_t W_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam wide_t W_MIN = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam sum_t  S_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam sum_t  S_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam wide_t RND   = wide_t'(1) << (FRAC - 1);
  localparam logic [WIDTH-1:0] L_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] L_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Upper lane of butterfly k; the lower lane sits GL above it.
  function automatic int lane_a(input int k);
    return (k / GL) * 2 * GL + (k % GL);
  endfunction

  function automatic wide_t sx_w(input logic [WIDTH-1:0] x);
    return {{(PW-WIDTH){x[WIDTH-1]}}, x};
  endfunction

  function automatic sum_t sx_s(input logic [WIDTH-1:0] x);
    return {{(SW-WIDTH){x[WIDTH-1]}}, x};
  endfunction

  function automatic logic [WIDTH-1:0] sat_w(input wide_t x);
    if (x > W_MAX)      return L_MAX;
    else if (x < W_MIN) return L_MIN;
    else                return x[WIDTH-1:0];
  endfunction

  function automatic logic ovf_w(input wide_t x);
    return (x > W_MAX) || (x < W_MIN);
  endfunction

  function automatic logic [WIDTH-1:0] sat_s(input sum_t x);
    if (x > S_MAX)      return L_MAX;
    else if (x < S_MIN) return L_MIN;
    else                return x[WIDTH-1:0];
  endfunction

  function automatic logic ovf_s(input sum_t x);
    return (x > S_MAX) || (x < S_MIN);
  endfunction

  // Halve with round-half-up when the beat asks for scaling.
  function automatic sum_t scl(input sum_t x, input logic s);
    return s ? ((x + sum_t'(1)) >>> 1) : x;
  endfunction

  logic          v1_q, v1_d, v2_q, v2_d, sc1_q, sc1_d, ovf_q, ovf_d;
  logic [BW-1:0] ar1_q, ar1_d, ai1_q, ai1_d, tr1_q, tr1_d, ti1_q, ti1_d;
  logic [LW-1:0] dr_q, dr_d, di_q, di_d;
  logic          en1, en2, sat1, sat2;
  logic [BW-1:0] ar_c, ai_c, tr_c, ti_c;
  logic [LW-1:0] dr_c, di_c;

  assign en2            = !v2_q || !bus.dout_busy;
  assign en1            = !v1_q || en2;
  assign bus.din_busy   = !en1;
  assign bus.dout_valid = v2_q;
  assign bus.dout_real  = dr_q;
  assign bus.dout_imag  = di_q;
  assign ovf            = ovf_q;

  // S1 datapath: pick a/b lanes, conjugate twiddle for IFFT, rounded complex multiply t = w*b.
  always_comb begin
    logic [WIDTH-1:0] wr, wi, wn, br, bi;
    wide_t            pr, pi;
    int               ia, ib;
    ar_c = '0;
    ai_c = '0;
    tr_c = '0;
    ti_c = '0;
    sat1 = 1'b0;
    wr = '0; wi = '0; wn = '0; br = '0; bi = '0;
    pr = '0; pi = '0;
    ia = 0; ib = 0;
    for (int k = 0; k < NB; k++) begin
      ia = lane_a(k);
      ib = ia + GL;
      wr = bus.din_weight_real[k*WIDTH +: WIDTH];
      wi = bus.din_weight_imag[k*WIDTH +: WIDTH];
      br = bus.din_real[ib*WIDTH +: WIDTH];
      bi = bus.din_imag[ib*WIDTH +: WIDTH];
      wn = wi;
      if (bus.din_inverse) begin
        if (wi == L_MIN) begin
          wn   = L_MAX;
          sat1 = 1'b1;
        end else begin
          wn = -wi;
        end
      end
      pr = ((sx_w(wr) * sx_w(br)) - (sx_w(wn) * sx_w(bi)) + RND) >>> FRAC;
      pi = ((sx_w(wn) * sx_w(br)) + (sx_w(wr) * sx_w(bi)) + RND) >>> FRAC;
      sat1 = sat1 | ovf_w(pr) | ovf_w(pi);
      tr_c[k*WIDTH +: WIDTH] = sat_w(pr);
      ti_c[k*WIDTH +: WIDTH] = sat_w(pi);
      ar_c[k*WIDTH +: WIDTH] = bus.din_real[ia*WIDTH +: WIDTH];
      ai_c[k*WIDTH +: WIDTH] = bus.din_imag[ia*WIDTH +: WIDTH];
    end
  end

  // S2 datapath: a+t to lane a, a-t to lane b, optionally halved, then saturated.
  always_comb begin
    sum_t sr, si, dr, di;
    int   ia, ib;
    dr_c = '0;
    di_c = '0;
    sat2 = 1'b0;
    sr = '0; si = '0; dr = '0; di = '0;
    ia = 0; ib = 0;
    for (int k = 0; k < NB; k++) begin
      ia = lane_a(k);
      ib = ia + GL;
      sr = scl(sx_s(ar1_q[k*WIDTH +: WIDTH]) + sx_s(tr1_q[k*WIDTH +: WIDTH]), sc1_q);
      si = scl(sx_s(ai1_q[k*WIDTH +: WIDTH]) + sx_s(ti1_q[k*WIDTH +: WIDTH]), sc1_q);
      dr = scl(sx_s(ar1_q[k*WIDTH +: WIDTH]) - sx_s(tr1_q[k*WIDTH +: WIDTH]), sc1_q);
      di = scl(sx_s(ai1_q[k*WIDTH +: WIDTH]) - sx_s(ti1_q[k*WIDTH +: WIDTH]), sc1_q);
      sat2 = sat2 | ovf_s(sr) | ovf_s(si) | ovf_s(dr) | ovf_s(di);
      dr_c[ia*WIDTH +: WIDTH] = sat_s(sr);
      di_c[ia*WIDTH +: WIDTH] = sat_s(si);
      dr_c[ib*WIDTH +: WIDTH] = sat_s(dr);
      di_c[ib*WIDTH +: WIDTH] = sat_s(di);
    end
  end

  // Stage advance: each register loads only when its stage is enabled; ovf is sticky, set beats clear.
  always_comb begin
    v1_d  = v1_q;
    v2_d  = v2_q;
    sc1_d = sc1_q;
    ar1_d = ar1_q;
    ai1_d = ai1_q;
    tr1_d = tr1_q;
    ti1_d = ti1_q;
    dr_d  = dr_q;
    di_d  = di_q;
    if (en1) begin
      v1_d = bus.din_valid;
      if (bus.din_valid) begin
        ar1_d = ar_c;
        ai1_d = ai_c;
        tr1_d = tr_c;
        ti1_d = ti_c;
        sc1_d = bus.din_scale;
      end
    end
    if (en2) begin
      v2_d = v1_q;
      if (v1_q) begin
        dr_d = dr_c;
        di_d = di_c;
      end
    end
    ovf_d = (ovf_q & ~ovf_clr) | (en1 & bus.din_valid & sat1) | (en2 & v1_q & sat2);
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      sc1_q <= 1'b0;
      ovf_q <= 1'b0;
      ar1_q <= '0;
      ai1_q <= '0;
      tr1_q <= '0;
      ti1_q <= '0;
      dr_q  <= '0;
      di_q  <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      sc1_q <= sc1_d;
      ovf_q <= ovf_d;
      ar1_q <= ar1_d;
      ai1_q <= ai1_d;
      tr1_q <= tr1_d;
      ti1_q <= ti1_d;
      dr_q  <= dr_d;
      di_q  <= di_d;
    end
  end
endmodule
